// File: rtl/sc_regbank.sv
// Parametrised register bank: one write port, two registered read ports, fixed register 0,
// and a soft-clear sweep. Define SC_REGBANK_BYPASS_EN for write-first read/write collisions.
module sc_regbank #(
    parameter int                         DATAWIDTH_BUS      = 32,
    parameter int                         ADDRWIDTH          = 5,
    parameter logic [DATAWIDTH_BUS-1:0]   DATA_REGFIXED_INIT = '0
) (
    input  logic                     SC_RegBANK_CLOCK_50,
    input  logic                     SC_RegBANK_RESET_InLow,
    input  logic [DATAWIDTH_BUS-1:0] SC_RegBANK_data_InBUS,
    input  logic [ADDRWIDTH-1:0]     SC_RegBANK_writeAddr_In,
    input  logic                     SC_RegBANK_write_InHigh,
    input  logic [ADDRWIDTH-1:0]     SC_RegBANK_readAddrA_In,
    input  logic [ADDRWIDTH-1:0]     SC_RegBANK_readAddrB_In,
    input  logic                     SC_RegBANK_clear_InHigh,
    output logic [DATAWIDTH_BUS-1:0] SC_RegBANK_dataA_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] SC_RegBANK_dataB_OutBUS,
    output logic                     SC_RegBANK_busy_OutHigh
);
    localparam int                   DEPTH     = 2 ** ADDRWIDTH;
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                 state, state_nxt;
    logic [ADDRWIDTH-1:0]   cnt, cnt_nxt;
    logic                   busy, busy_nxt;
    logic                   wr_accept;
    logic                   clr_en;
    logic [DATAWIDTH_BUS-1:0] mem [DEPTH];
    logic [DATAWIDTH_BUS-1:0] rd_a_nxt, rd_b_nxt;

    // Sweep sequencer
    always_ff @(posedge SC_RegBANK_CLOCK_50 or negedge SC_RegBANK_RESET_InLow) begin
        if (!SC_RegBANK_RESET_InLow) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                if (SC_RegBANK_clear_InHigh) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = ADDRWIDTH'(1);
                    busy_nxt  = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt == LAST_ADDR) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + ADDRWIDTH'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign clr_en    = (state == CLEAR);
    assign wr_accept = (state == IDLE) && SC_RegBANK_write_InHigh &&
                       (SC_RegBANK_writeAddr_In != '0);

    // Register 0 is a constant; the rest are individual flop rows.
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_reg
            if (g == 0) begin : g_fixed
                assign mem[g] = DATA_REGFIXED_INIT;
            end else begin : g_flop
                logic [DATAWIDTH_BUS-1:0] q;
                always_ff @(posedge SC_RegBANK_CLOCK_50 or negedge SC_RegBANK_RESET_InLow) begin
                    if (!SC_RegBANK_RESET_InLow)
                        q <= DATA_REGFIXED_INIT;
                    else if (clr_en && (cnt == ADDRWIDTH'(g)))
                        q <= DATA_REGFIXED_INIT;
                    else if (wr_accept && (SC_RegBANK_writeAddr_In == ADDRWIDTH'(g)))
                        q <= SC_RegBANK_data_InBUS;
                end
                assign mem[g] = q;
            end
        end
    endgenerate

    // Read muxes; the sweep never feeds the bypass path since wr_accept is IDLE-only.
    always_comb begin
        rd_a_nxt = mem[SC_RegBANK_readAddrA_In];
        rd_b_nxt = mem[SC_RegBANK_readAddrB_In];
`ifdef SC_REGBANK_BYPASS_EN
        if (wr_accept && (SC_RegBANK_writeAddr_In == SC_RegBANK_readAddrA_In))
            rd_a_nxt = SC_RegBANK_data_InBUS;
        if (wr_accept && (SC_RegBANK_writeAddr_In == SC_RegBANK_readAddrB_In))
            rd_b_nxt = SC_RegBANK_data_InBUS;
`else
        rd_a_nxt = rd_a_nxt;
        rd_b_nxt = rd_b_nxt;
`endif
    end

    always_ff @(posedge SC_RegBANK_CLOCK_50 or negedge SC_RegBANK_RESET_InLow) begin
        if (!SC_RegBANK_RESET_InLow) begin
            SC_RegBANK_dataA_OutBUS <= DATA_REGFIXED_INIT;
            SC_RegBANK_dataB_OutBUS <= DATA_REGFIXED_INIT;
        end else begin
            SC_RegBANK_dataA_OutBUS <= rd_a_nxt;
            SC_RegBANK_dataB_OutBUS <= rd_b_nxt;
        end
    end

    assign SC_RegBANK_busy_OutHigh = busy;

endmodule

// File: tb/tb_sc_regbank.sv
// Randomised self-checking bench for sc_regbank against an array/cycle-count reference model.
module tb_sc_regbank;
    localparam int          W     = 32;
    localparam int          AW    = 5;
    localparam int          DEPTH = 32;
    localparam logic [W-1:0] INIT = 32'h0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  din;
    logic [AW-1:0] wa, ra, rb;
    logic          we, clr;
    logic [W-1:0]  qa, qb;
    logic          busy;

    sc_regbank #(.DATAWIDTH_BUS(W), .ADDRWIDTH(AW), .DATA_REGFIXED_INIT(INIT)) dut (
        .SC_RegBANK_CLOCK_50     (clk),
        .SC_RegBANK_RESET_InLow  (rst_n),
        .SC_RegBANK_data_InBUS   (din),
        .SC_RegBANK_writeAddr_In (wa),
        .SC_RegBANK_write_InHigh (we),
        .SC_RegBANK_readAddrA_In (ra),
        .SC_RegBANK_readAddrB_In (rb),
        .SC_RegBANK_clear_InHigh (clr),
        .SC_RegBANK_dataA_OutBUS (qa),
        .SC_RegBANK_dataB_OutBUS (qb),
        .SC_RegBANK_busy_OutHigh (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents plus the edge number at which a sweep began.
    logic [W-1:0] mdl [DEPTH];
    bit           sweeping;
    int           t0;
    int           edge_no;
    logic [W-1:0] exp_a, exp_b;
    logic         exp_busy;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl[i] = INIT;
        sweeping = 0;
        exp_a    = INIT;
        exp_b    = INIT;
        exp_busy = 1'b0;
    endtask

    // One rising edge: model computed from inputs as they stand, then sampled 1ns after.
    task automatic tick();
        logic [W-1:0] na, nb;
        int           k;
        edge_no++;
        na = mdl[ra];
        nb = mdl[rb];
        if (sweeping) begin
            k = edge_no - t0;
            mdl[k] = INIT;
            if (k == DEPTH - 1) sweeping = 0;
        end else begin
`ifdef SC_REGBANK_BYPASS_EN
            if (we && wa != 0 && wa == ra) na = din;
            if (we && wa != 0 && wa == rb) nb = din;
`endif
            if (we && wa != 0) mdl[wa] = din;
            if (clr) begin
                sweeping = 1;
                t0       = edge_no;
            end
        end
        @(posedge clk);
        #1;
        exp_a    = na;
        exp_b    = nb;
        exp_busy = sweeping;
    endtask

    task automatic idle_inputs();
        we = 0; clr = 0; wa = '0; din = '0; ra = '0; rb = '0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            we = 1; wa = AW'($urandom_range(1, DEPTH - 1)); din = $urandom;
            tick();
        end
        idle_inputs();
        rst_n = 0;
        #2;
        model_reset();
        n_checks++;
        if (qa !== INIT || qb !== INIT || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: a=%h b=%h busy=%b required a=%h b=%h busy=0", qa, qb, busy, INIT, INIT);
        end
        rst_n = 1;
        for (int i = 0; i < DEPTH; i++) begin
            ra = AW'(i); rb = AW'(DEPTH - 1 - i);
            tick();
            n_checks++;
            if (qa !== INIT || qb !== INIT) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: a=%h b=%h required %h", i, qa, qb, INIT);
            end
        end
    endtask

    task automatic test_write_read();
        we = 1; wa = 7; din = 32'hDEADBEEF;
        tick();
        we = 0; ra = 7; rb = 7;
        tick();
        n_checks++;
        if (qa !== 32'hDEADBEEF || qb !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write7: a=%h b=%h required deadbeef", qa, qb);
        end
        we = 1; wa = 0; din = 32'h12345678;
        tick();
        we = 0; ra = 0; rb = 0;
        tick();
        n_checks++;
        if (qa !== INIT || qb !== INIT) begin
            n_fail++;
            $display("FAIL write0: a=%h b=%h required %h", qa, qb, INIT);
        end
    endtask

    task automatic test_collision();
        logic [W-1:0] want;
        we = 1; wa = 3; din = 32'h11;
        tick();
        we = 1; wa = 3; din = 32'hA5A5A5A5; ra = 3; rb = 0;
        tick();
`ifdef SC_REGBANK_BYPASS_EN
        want = 32'hA5A5A5A5;
`else
        want = 32'h11;
`endif
        n_checks++;
        if (qa !== want || qb !== INIT) begin
            n_fail++;
            $display("FAIL collision: a=%h b=%h required a=%h b=%h", qa, qb, want, INIT);
        end
        we = 1; wa = 0; din = 32'hCAFEF00D; ra = 0; rb = 0;
        tick();
        n_checks++;
        if (qa !== INIT || qb !== INIT) begin
            n_fail++;
            $display("FAIL collision0: a=%h b=%h required %h", qa, qb, INIT);
        end
        idle_inputs();
        ra = 3;
        tick();
        n_checks++;
        if (qa !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL collision_after: a=%h required a5a5a5a5", qa);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            we  = ($urandom_range(0, 2) != 0);
            wa  = AW'($urandom);
            din = $urandom;
            ra  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            clr = ($urandom_range(0, 60) == 0);
            tick();
            n_checks++;
            if (qa !== exp_a || qb !== exp_b || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL random[%0d]: a=%h b=%h busy=%b required a=%h b=%h busy=%b",
                         i, qa, qb, busy, exp_a, exp_b, exp_busy);
            end
        end
        idle_inputs();
        for (int i = 0; i < 40 && busy; i++) tick();
    endtask

    task automatic test_clear();
        int nb;
        for (int i = 1; i < DEPTH; i++) begin
            we = 1; wa = AW'(i); din = W'(i);
            tick();
        end
        we = 0; clr = 1;
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 8) begin we = 1; wa = 5; din = 32'hFF; end
            else we = 0;
            ra = AW'($urandom); rb = AW'($urandom);
            tick();
            clr = 0;
            n_checks++;
            if (qa !== exp_a || qb !== exp_b || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL sweep_cyc[%0d]: a=%h b=%h busy=%b required a=%h b=%h busy=%b",
                         i, qa, qb, busy, exp_a, exp_b, exp_busy);
            end
            if (busy) nb++;
            else break;
        end
        n_checks++;
        if (nb != DEPTH - 1) begin
            n_fail++;
            $display("FAIL busy_len: got %0d cycles required %0d", nb, DEPTH - 1);
        end
        // first cycle with busy low must accept a write
        we = 1; wa = 9; din = 32'h99;
        tick();
        we = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ra = AW'(i); rb = AW'(i);
            tick();
            n_checks++;
            if (qa !== ((i == 9) ? 32'h99 : INIT) || qb !== qa) begin
                n_fail++;
                $display("FAIL post_clear[%0d]: a=%h b=%h required %h", i, qa, qb,
                         (i == 9) ? 32'h99 : INIT);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int i = 1; i < DEPTH; i++) begin
            we = 1; wa = AW'(i); din = $urandom;
            tick();
        end
        we = 0; clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 9; i++) tick();
        rst_n = 0;
        #1;
        model_reset();
        n_checks++;
        if (busy !== 1'b0 || qa !== INIT || qb !== INIT) begin
            n_fail++;
            $display("FAIL reset_mid_sweep: busy=%b a=%h b=%h required busy=0 a=b=%h", busy, qa, qb, INIT);
        end
        #1;
        rst_n = 1;
        for (int i = 0; i < DEPTH; i++) begin
            ra = AW'(i); rb = AW'($urandom);
            tick();
            n_checks++;
            if (qa !== INIT || qb !== INIT || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL after_abort[%0d]: a=%h b=%h busy=%b required %h/0", i, qa, qb, busy, INIT);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic b [70];
        int   ones1, ones2;
        clr = 1;
        for (int i = 0; i < 70; i++) begin
            tick();
            b[i] = busy;
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL b2b_busy[%0d]: got %b required %b", i, busy, exp_busy);
            end
        end
        clr = 0;
        ones1 = 0; ones2 = 0;
        for (int i = 0; i < 31; i++) ones1 += int'(b[i]);
        for (int i = 32; i < 63; i++) ones2 += int'(b[i]);
        n_checks++;
        if (ones1 != 31 || b[31] !== 1'b0 || ones2 != 31 || b[63] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pattern: run1=%0d gap=%b run2=%0d gap2=%b required 31/0/31/0",
                     ones1, b[31], ones2, b[63]);
        end
        for (int i = 0; i < 40 && busy; i++) tick();
    endtask

    initial begin
        edge_no = 0;
        idle_inputs();
        rst_n = 0;
        model_reset();
        #12;
        rst_n = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_collision();
        test_random();
        test_clear();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
